// File: rtl/bus_mem_responder.sv
// Word-addressed RAM responder for the single-outstanding bus handshake.
// Optional address range checking is enabled with `define BUS_RESP_RANGE_CHECK_EN.
module bus_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BUS_start_transaction,
  input  logic        BUS_mode,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  output logic [31:0] BUS_rdata,
  output logic        BUS_rdata_valid,
  output logic        BUS_write_done,
  output logic        BUS_busy,
  output logic        BUS_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               mode_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic               bad_c;
  logic               we_c;
  logic [31:0]        mem [DEPTH];

`ifdef BUS_RESP_RANGE_CHECK_EN
  logic               bad_q;
  logic               err_q;

  // Misaligned or beyond the RAM: flagged at acceptance, answered with BUS_err.
  assign bad_c   = bad_q;
  assign BUS_err = err_q;
`else
  // Without checking, the low bits and bits above the index are simply dropped.
  wire unused_addr_c = ^{BUS_addr[31:DEPTH_LOG2+2], BUS_addr[1:0]};

  assign bad_c   = 1'b0;
  assign BUS_err = 1'b0;
`endif

  // The RAM write coincides with the WAIT->RESP transition.
  assign we_c = (state == WAIT) && (cnt == '0) && mode_q && !bad_c && !rst;

  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Handshake FSM with registered response pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      mode_q          <= 1'b0;
      idx_q           <= '0;
      wdata_q         <= 32'h0;
      BUS_rdata       <= 32'h0;
      BUS_rdata_valid <= 1'b0;
      BUS_write_done  <= 1'b0;
      BUS_busy        <= 1'b0;
`ifdef BUS_RESP_RANGE_CHECK_EN
      bad_q           <= 1'b0;
      err_q           <= 1'b0;
`endif
    end else begin
      BUS_rdata_valid <= 1'b0;
      BUS_write_done  <= 1'b0;
`ifdef BUS_RESP_RANGE_CHECK_EN
      err_q           <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (BUS_start_transaction) begin
            mode_q   <= BUS_mode;
            idx_q    <= BUS_addr[DEPTH_LOG2+1:2];
            wdata_q  <= BUS_wdata;
            cnt      <= CNT_W'(WAIT_CYCLES);
            BUS_busy <= 1'b1;
            state    <= WAIT;
`ifdef BUS_RESP_RANGE_CHECK_EN
            bad_q    <= (BUS_addr[1:0] != 2'b00) || (BUS_addr[31:DEPTH_LOG2+2] != '0);
`endif
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= RESP;
            if (bad_c) begin
`ifdef BUS_RESP_RANGE_CHECK_EN
              err_q <= 1'b1;
`endif
            end else if (mode_q) begin
              BUS_write_done <= 1'b1;
            end else begin
              BUS_rdata       <= mem[idx_q];
              BUS_rdata_valid <= 1'b1;
            end
          end
        end
        RESP: begin
          BUS_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          BUS_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Memory-side responder for the CPU's single-outstanding bus transaction protocol. It is driven by the `BUS_start_transaction`, `BUS_mode`, address and write-data signals from the control unit and datapath. It answers each transaction from an internal word-addressed RAM with a one-cycle `BUS_rdata_valid` or `BUS_write_done` pulse after a programmable number of wait states. It is the component that closes the loop on the control unit's bus handshake in simulation and on FPGA.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: log2 of the RAM depth in 32-bit words; the default is 1024 words (4 KiB).
- `WAIT_CYCLES`, 2: wait states inserted between acceptance and response; legal range 0–15.

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `BUS_start_transaction`  in  1  request strobe; sampled only in IDLE.
- `BUS_mode`  in  1  0 = read, 1 = write; latched at acceptance.
- `BUS_addr`  in  32  byte address; latched at acceptance.
- `BUS_wdata`  in  32  write data; latched at acceptance.
- `BUS_rdata`  out  32  read data; valid while `BUS_rdata_valid`=1 and held afterwards.
- `BUS_rdata_valid`  out  1  one-cycle read-completion pulse.
- `BUS_write_done`  out  1  one-cycle write-completion pulse.
- `BUS_busy`  out  1  high from acceptance until return to IDLE.
- `BUS_err`  out  1  one-cycle error pulse; constant 0 unless the macro is defined.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - If `BUS_start_transaction`=1 at a rising edge, latch mode, addr and wdata.
  - Load the wait counter with `WAIT_CYCLES` and go to WAIT.
- **WAIT**
  - If counter ≠ 0, decrement and stay in WAIT.
  - If counter = 0, go to RESP on the next edge.
- **Entry to RESP** (registered at the same edge):
  - Read: `BUS_rdata` ← `mem[addr[DEPTH_LOG2+1:2]]`; `BUS_rdata_valid` ← 1.
  - Write: `mem[addr[DEPTH_LOG2+1:2]]` ← wdata; `BUS_write_done` ← 1.
- **RESP**
  - Lasts exactly one cycle, then returns to IDLE unconditionally.
  - Pulses are deasserted at that edge.
  - `BUS_start_transaction` during WAIT or RESP is ignored; no queueing.
- A strobe still high when the block returns to IDLE is accepted as a new transaction. The master must drop the strobe once it sees the response pulse.
- **Address handling:**
  - Bits [1:0] are ignored.
  - Index = `addr[DEPTH_LOG2+1:2]`; upper bits are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2.
- **RAM** is not cleared by reset; its content before the first write is undefined.
- **Reset mid-transaction:**
  - Returns the block to IDLE at once; no response pulse is issued.
  - A pending write is dropped, and RAM content is otherwise retained.

## Timing
- **Reset values:** state IDLE; `BUS_rdata`=32'h0; `BUS_rdata_valid`, `BUS_write_done`, `BUS_busy` and `BUS_err` all 0.
- **Latency:** request accepted at edge N → response pulse high from edge N+1+WAIT_CYCLES to edge N+2+WAIT_CYCLES.
- **Busy window:** `BUS_busy` is high from edge N to edge N+2+WAIT_CYCLES.
- **Back-to-back throughput:** the earliest next acceptance is edge N+3+WAIT_CYCLES, so back-to-back transactions take WAIT_CYCLES+3 cycles each.
- **Response pulses:**
  - `BUS_rdata_valid` and `BUS_write_done` are never high together.
  - Each pulse is exactly one cycle wide.
- **Held read data:** `BUS_rdata` changes only on a read response and holds its value through later writes.
- **WAIT_CYCLES=0:** still passes through one WAIT cycle, giving a response at N+1.

## Configuration
- Macro: `BUS_RESP_RANGE_CHECK_EN`.
- **Defined:** a transaction is an error if `addr[1:0]` ≠ 0 or `addr` ≥ 4·2^DEPTH_LOG2. An error transaction:
  - pulses `BUS_err` in place of `BUS_rdata_valid` or `BUS_write_done`, with the same timing;
  - does not write RAM and leaves `BUS_rdata` unchanged.
- **Undefined:** no checking is done, address wrap and low-bit masking apply as above, and `BUS_err` is tied to 0.

## Test plan
- **Write then read:** reset, write 32'hDEADBEEF to 0x10, then read 0x10 with WAIT_CYCLES=2.
  - `BUS_write_done` is high 3 cycles after acceptance, for 1 cycle.
  - `BUS_rdata_valid` pulses with `BUS_rdata`=32'hDEADBEEF 3 cycles after the read is accepted.
- **Strobe ignored while busy:** assert a second strobe during WAIT.
  - Exactly one response occurs.
  - The second request is taken only after `BUS_busy` falls, and the pair of transactions takes 5 cycles each.
- **Reset during WAIT of a write:** write 32'h1 to 0x20, then issue a `rst` pulse while in WAIT.
  - No `BUS_write_done` is issued and all outputs return to 0.
  - A subsequent read of 0x20 returns its prior value 32'hA5A5A5A5.
- **Address wrap, macro undefined:** write 32'h12345678 to 0x1004, then read 0x0004.
  - Read returns 32'h12345678.
  - Read of 0x0006 returns the same word.
- **Range check, macro defined:** write to 0x0002, then write to 0x1000.
  - Each transaction pulses `BUS_err` at N+3 and does not pulse `BUS_write_done`.
  - RAM is unchanged.
- **WAIT_CYCLES=0 build:** a read accepted at edge N gives `BUS_rdata_valid` high from edge N+1 to edge N+2, and `BUS_busy` falls at edge N+2.
